// File: rtl/spin_ctrl.sv
// spin_ctrl: button-driven wheel controller (SPIN -> BRAKE -> STOPPED) with tick prescaler and LFSR.
// Define SPIN_BRAKE_EN to lengthen the tick period by BRAKE_STEP at every tick while braking.
module spin_ctrl #(
    parameter logic [15:0] TICK_FAST  = 16'd1000,
    parameter logic [15:0] BRAKE_STEP = 16'd250,
    parameter logic [15:0] TICK_MAX   = 16'd20000,
    parameter logic [15:0] LOCKOUT    = 16'd5000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_i,
    input  logic       running_i,
    input  logic [2:0] pos_i,
    output logic       tick_o,
    output logic       stop_o,
    output logic [3:0] rand_o,
    output logic       win_o,
    output logic [3:0] jackpots_o,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        SPIN    = 2'd0,
        BRAKE   = 2'd1,
        STOPPED = 2'd2
    } state_t;

`ifdef SPIN_BRAKE_EN
    localparam logic [16:0] STEP = 17'(BRAKE_STEP);
`else
    // Deceleration compiled out: the step is forced to zero so the period never moves.
    localparam logic [16:0] STEP = 17'(BRAKE_STEP) & 17'd0;
`endif

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        btn_q;
    logic        run_q;
    logic        run_d;
    logic [15:0] lockout_cnt;
    logic [15:0] period;
    logic [15:0] count;

    logic        press_c;
    logic        fall_c;
    logic        at_end_c;
    logic [16:0] period_sum_c;
    logic [15:0] period_brk_c;

    // Press = rising edge of synchronized button outside the lockout window.
    assign press_c      = sync2 & ~btn_q & (lockout_cnt == 16'd0);
    assign fall_c       = run_d & ~run_q;
    assign at_end_c     = (count == (period - 16'd1));
    assign period_sum_c = {1'b0, period} + STEP;
    assign period_brk_c = (period_sum_c > {1'b0, TICK_MAX}) ? TICK_MAX : period_sum_c[15:0];
    assign state_o      = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= SPIN;
            tick_o      <= 1'b0;
            stop_o      <= 1'b0;
            win_o       <= 1'b0;
            jackpots_o  <= 4'd0;
            rand_o      <= 4'b0001;
            period      <= TICK_FAST;
            count       <= 16'd0;
            lockout_cnt <= 16'd0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            btn_q       <= 1'b0;
            run_q       <= 1'b0;
            run_d       <= 1'b0;
        end else begin
            sync1  <= btn_i;
            sync2  <= sync1;
            btn_q  <= sync2;
            run_q  <= running_i;
            run_d  <= run_q;
            rand_o <= {rand_o[2:0], rand_o[3] ^ rand_o[2]};
            win_o  <= 1'b0;

            if (lockout_cnt != 16'd0) begin
                lockout_cnt <= lockout_cnt - 16'd1;
            end

            // Free-running prescaler; keeps ticking in every state.
            if (at_end_c) begin
                tick_o <= 1'b1;
                count  <= 16'd0;
            end else begin
                tick_o <= 1'b0;
                count  <= count + 16'd1;
            end

            case (state)
                SPIN: begin
                    if (press_c) begin
                        state       <= BRAKE;
                        stop_o      <= 1'b1;
                        lockout_cnt <= LOCKOUT;
                    end
                end
                BRAKE: begin
                    if (at_end_c) begin
                        period <= period_brk_c;
                    end
                    if (fall_c) begin
                        state <= STOPPED;
                        if (pos_i == 3'd0) begin
                            win_o <= 1'b1;
                            if (jackpots_o != 4'd15) begin
                                jackpots_o <= jackpots_o + 4'd1;
                            end
                        end
                    end
                end
                STOPPED: begin
                    if (press_c) begin
                        state       <= SPIN;
                        stop_o      <= 1'b0;
                        lockout_cnt <= LOCKOUT;
                        period      <= TICK_FAST;
                        count       <= 16'd0;
                        tick_o      <= 1'b0;
                    end
                end
                default: begin
                    state  <= SPIN;
                    stop_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/spin_ctrl.md
SPIN_CTRL -- requirements
Module: spin_ctrl

Interface
REQ-001 Parameter TICK_FAST, default 16'd1000, SHALL set the tick period in clock cycles while spinning (legal range 2..TICK_MAX).
REQ-002 Parameter BRAKE_STEP, default 16'd250, SHALL set the per-tick period increment while braking.
REQ-003 Parameter TICK_MAX, default 16'd20000, SHALL set the saturation ceiling for the tick period.
REQ-004 Parameter LOCKOUT, default 16'd5000, SHALL set the cycles after an accepted press during which further presses are ignored.
REQ-005 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 btn_i  input  1  raw, asynchronous user button, active-high.
REQ-008 tick_o  output  1  one-cycle spin-step pulse to the wheel.
REQ-009 stop_o  output  1  level stop request to the wheel.
REQ-010 rand_o  output  4  pseudo-random value to the wheel, always in 1..15.
REQ-011 running_i  input  1  wheel spinning flag.
REQ-012 pos_i  input  3  wheel position, 0..5.
REQ-013 win_o  output  1  one-cycle pulse when the wheel stops on segment 0.
REQ-014 jackpots_o  output  4  count of segment-0 stops.
REQ-015 state_o  output  2  current FSM state: SPIN=0, BRAKE=1, STOPPED=2.

Function
REQ-016 btn_i SHALL pass through a 2-flop synchronizer; a press SHALL be a 0->1 edge of the synchronized level with lockout_cnt==0.
REQ-017 An accepted press SHALL load lockout_cnt with LOCKOUT, which SHALL decrement to 0 once per cycle.
REQ-018 The prescaler SHALL count 0..period-1; tick_o SHALL pulse for exactly one cycle when count==period-1, and count SHALL then return to 0.
REQ-019 rand_o SHALL be a 4-bit maximal LFSR (x^4+x^3+1) stepping every cycle; it SHALL never be 0.
REQ-020 SPIN: stop_o=0, period=TICK_FAST; an accepted press SHALL move to BRAKE, with stop_o=1 from the next cycle.
REQ-021 BRAKE: stop_o=1; a 1->0 transition of registered running_i SHALL move to STOPPED.
REQ-022 On entry to STOPPED: if pos_i==0, win_o SHALL pulse one cycle and jackpots_o SHALL increment, saturating at 15.
REQ-023 STOPPED: stop_o=1; an accepted press SHALL move to SPIN, clear stop_o next cycle, reset period to TICK_FAST, and clear the prescaler.
REQ-024 Presses in BRAKE SHALL be ignored and SHALL NOT load lockout.
REQ-025 If a press and the running_i fall coincide in BRAKE, only the stop transition SHALL occur.
REQ-026 Period arithmetic SHALL be 17-bit internally; a result above TICK_MAX SHALL clamp to TICK_MAX.
REQ-027 Ticks SHALL continue in STOPPED at the current period, which the wheel ignores.

Reset
REQ-028 When rst_i is asserted, the block SHALL immediately set: state=SPIN, tick_o=0, stop_o=0, win_o=0, jackpots_o=0, period=TICK_FAST, prescaler=0, lockout_cnt=0, synchronizer=0, LFSR=4'b0001.
REQ-029 Reset mid-BRAKE or mid-lockout SHALL discard all progress; the first tick after release SHALL occur TICK_FAST cycles later.

Configuration
REQ-030 With SPIN_BRAKE_EN defined, period SHALL increase by BRAKE_STEP at each tick_o while in BRAKE (deceleration), clamped per REQ-026.
REQ-031 Without SPIN_BRAKE_EN, period SHALL remain TICK_FAST in all states, and BRAKE_STEP SHALL be unused.

Verification
REQ-032 Reset release, TICK_FAST=4 -> tick_o pulses at cycles 4, 8, 12; stop_o=0; state_o=0.
REQ-033 Press in SPIN -> stop_o=1 and state_o=1 within 4 cycles of the btn_i rise; a second press inside LOCKOUT -> no state change.
REQ-034 SPIN_BRAKE_EN, TICK_FAST=4, BRAKE_STEP=2, TICK_MAX=9 -> BRAKE tick intervals 4, 6, 8, 9, 9.
REQ-035 running_i falls with pos_i=0 -> win_o high for one cycle, jackpots_o 0->1, state_o=2; 16 such stops -> jackpots_o holds 15.
REQ-036 Press in STOPPED -> state_o=0, stop_o=0, next tick after TICK_FAST cycles; rst_i pulse in BRAKE -> all outputs at reset values in the same cycle.
